bram_port_arbiter: RTL and testbench
====================================

# bram_port_arbiter

Shares the single-port BLOCK_MEM sample buffer (DEPTH words × DATA_W) between two requesters: the sample-ingest writer and the RLS core reader. The block performs round-robin arbitration, registers the winning access onto the BRAM port, and returns read data with a `r_valid` strobe aligned to the BRAM read latency. Out-of-range addresses are consumed without touching memory and are flagged.

## Interface

**Parameters**
- `DATA_W`, 32: data word width.
- `ADDR_W`, 32: address width; matches the BLOCK_MEM port.
- `DEPTH`, 98304: number of valid words; legal addresses are 0..DEPTH-1.
- `RD_LAT`, 1: BRAM read latency in cycles, from address-sampling edge to `douta` valid; legal range 1..4.

**Ports**
- `clka` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `w_req` in 1: writer request.
- `w_addr` in ADDR_W: write address.
- `w_data` in DATA_W: write data.
- `w_gnt` out 1: combinational; the write is accepted in any cycle where `w_req && w_gnt`.
- `r_req` in 1: reader request.
- `r_addr` in ADDR_W: read address.
- `r_gnt` out 1: combinational; the read is accepted in any cycle where `r_req && r_gnt`.
- `r_data` out DATA_W: direct pass-through of `bram_douta`.
- `r_valid` out 1: `r_data` holds the result of an accepted read.
- `bram_wea` out 1: registered write enable to the BRAM.
- `bram_addra` out ADDR_W: registered BRAM address.
- `bram_dina` out DATA_W: registered BRAM write data.
- `bram_douta` in DATA_W: BRAM read data.
- `err_oor` out 1: one-cycle pulse on an accepted out-of-range request.
- `err_sticky` out 1: set by `err_oor`, cleared by `err_clr`.
- `err_clr` in 1: synchronous clear of `err_sticky`.

## Operation

- **Arbitration.** At most one grant per cycle.
  - If only one requester asserts its request, that requester is granted.
  - If both assert, the requester named by `prio` is granted.
  - After each grant, `prio` switches to the other requester.
  - `prio` resets to writer.
  - A grant is never asserted without the matching request.
- **Accepted in-range write** (`w_addr < DEPTH`): on the next edge, `bram_wea`=1, `bram_addra`=`w_addr`, `bram_dina`=`w_data`.
- **Accepted in-range read**: on the next edge, `bram_wea`=0 and `bram_addra`=`r_addr`. A 1 enters the valid shift register (depth 1+RD_LAT).
- **Idle cycle:** `bram_wea`=0. `bram_addra` and `bram_dina` hold their previous values.
- **Out-of-range accepted request** (`addr >= DEPTH`):
  - The grant is still given and the request is consumed.
  - `bram_wea` stays 0, and no `r_valid` is generated.
  - `err_oor` pulses one cycle later.
- **Error clear:** if `err_clr` and a new `err_oor` occur in the same cycle, the set wins and `err_sticky` stays 1.
- **Address comparison** is unsigned over the full ADDR_W.
- **Reset values:**
  - `bram_wea`, `bram_addra`, `bram_dina`, `r_valid`, `err_oor`, `err_sticky` = 0.
  - The valid pipeline is cleared and `prio` = writer.
  - `w_gnt` and `r_gnt` follow their requests combinationally, which gives writer priority on a tie.
- **Reset mid-operation:** in-flight reads are dropped and no `r_valid` is issued for them. A BRAM write whose `bram_wea` register is cleared before its sampling edge is lost.

## Timing

- Grant in cycle T → BRAM port driven during T+1 → the BRAM samples at the end of T+1.
- Read accepted in T → `r_valid`=1 and `r_data` valid in cycle T+1+RD_LAT. With RD_LAT=1 this is T+2.
- Throughput: one access per cycle. Back-to-back reads produce back-to-back `r_valid`.
- Both requesters held high continuously → strict alternation W,R,W,R…
- Read-after-write to the same address, granted in consecutive cycles, returns the new data. Read-during-write behaviour of BLOCK_MEM is not relied upon, because the accesses are serialized.
- `err_oor` is high in T+1 for an out-of-range grant in T.

## Structure

- **Package `bram_arb_pkg`:**
  - `DEPTH_DEFAULT` = 98304.
  - `ADDR_W` and `DATA_W` defaults.
  - Enum `req_id_t` {REQ_W=0, REQ_R=1} used for `prio`.
- **Sub-module `rr_arb2`:** two-way round-robin arbiter.
  - Inputs: `clka`, `rst`, `req[1:0]`.
  - Outputs: one-hot `gnt[1:0]`.
  - Owns the `prio` register.
- The top level holds the port registers, the range check, the valid shift register and the error flags.

## Test plan

- **Reset check:** assert `rst` mid-stream with 3 reads in flight (RD_LAT=2) → all outputs are 0 and no `r_valid` appears afterwards. With `w_req`=`r_req`=1 after release, the first grant goes to the writer.
- **Fill then readback:** write addresses 0..98303 with data=addr+1, then read 0..98303 → `r_valid` at grant+2 (RD_LAT=1), `r_data`=addr+1 for every word, with no gaps.
- **Contention:** `w_req` and `r_req` high for 10 cycles → grants alternate W,R,W,R…; 5 writes, 5 reads.
- **Read-after-write:** write 0xDEADBEEF to addr 7, read addr 7 in the next cycle → `r_data`=0xDEADBEEF.
- **Out of range:** read addr 98304, write addr 0xFFFFFFFF → both granted, `bram_wea` stays 0, no `r_valid`, two `err_oor` pulses, `err_sticky`=1. Assert `err_clr` in the same cycle as a third `err_oor` pulse → `err_sticky` remains 1.
- **RD_LAT=4 sweep:** 4 consecutive reads → 4 consecutive `r_valid` pulses starting at grant+5, with data in order.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared defaults and requester ids for the sample buffer arbiter
package bram_arb_pkg;

    localparam int DEPTH_DEFAULT  = 98304;
    localparam int ADDR_W_DEFAULT = 32;
    localparam int DATA_W_DEFAULT = 32;

    typedef enum logic {
        REQ_W = 1'b0,
        REQ_R = 1'b1
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_W) ? REQ_R : REQ_W;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter; bit 0 is the writer, bit 1 the reader
module rr_arb2
    import bram_arb_pkg::*;
(
    input  logic       clka,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    req_id_t prio;
    req_id_t prio_next;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            prio <= REQ_W;
        end else begin
            prio <= prio_next;
        end
    end

    // A lone request always wins; prio only matters on a tie.
    always_comb begin
        gnt       = 2'b00;
        prio_next = prio;
        if (req[0] && (!req[1] || prio == REQ_W)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
        if (gnt[0]) begin
            prio_next = other_req(REQ_W);
        end else if (gnt[1]) begin
            prio_next = other_req(REQ_R);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares one BRAM port between the ingest writer and the RLS reader
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int ADDR_W = ADDR_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rst,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_gnt,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [DATA_W-1:0] bram_dina,
    input  logic [DATA_W-1:0] bram_douta,
    output logic              err_oor,
    output logic              err_sticky,
    input  logic              err_clr
);

    // Widened so the unsigned compare stays correct whatever ADDR_W is.
    localparam logic [63:0] DEPTH_L = 64'(DEPTH);

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            w_acc;
    logic            r_acc;
    logic            w_oor;
    logic            r_oor;
    logic            wr_hit;
    logic            rd_hit;
    logic            oor_hit;
    logic [RD_LAT:0] vld_sr;

    assign req = {r_req, w_req};

    rr_arb2 u_arb (
        .clka (clka),
        .rst  (rst),
        .req  (req),
        .gnt  (gnt)
    );

    assign w_gnt = gnt[0];
    assign r_gnt = gnt[1];

    always_comb begin
        w_acc   = w_req && gnt[0];
        r_acc   = r_req && gnt[1];
        w_oor   = 64'(w_addr) >= DEPTH_L;
        r_oor   = 64'(r_addr) >= DEPTH_L;
        wr_hit  = w_acc && !w_oor;
        rd_hit  = r_acc && !r_oor;
        oor_hit = (w_acc && w_oor) || (r_acc && r_oor);
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            bram_wea   <= 1'b0;
            bram_addra <= '0;
            bram_dina  <= '0;
            vld_sr     <= '0;
            err_oor    <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            bram_wea <= wr_hit;
            if (wr_hit) begin
                bram_addra <= w_addr;
                bram_dina  <= w_data;
            end else if (rd_hit) begin
                bram_addra <= r_addr;
            end
            vld_sr  <= {vld_sr[RD_LAT-1:0], rd_hit};
            err_oor <= oor_hit;
            // A pulse arriving together with a clear keeps the flag set.
            err_sticky <= err_oor || (err_sticky && !err_clr);
        end
    end

    assign r_valid = vld_sr[RD_LAT];
    assign r_data  = bram_douta;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - randomized bench for bram_port_arbiter at read latencies 1, 2 and 4
module tb_bram_port_arbiter;

    localparam int DEPTH = 98304;
    localparam int NI    = 3;

    logic        clka;
    logic        rst;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        r_req;
    logic [31:0] r_addr;
    logic        err_clr;

    logic        w_gnt_o    [NI];
    logic        r_gnt_o    [NI];
    logic [31:0] r_data_o   [NI];
    logic        r_valid_o  [NI];
    logic        wea_o      [NI];
    logic [31:0] addra_o    [NI];
    logic [31:0] dina_o     [NI];
    logic [31:0] douta_i    [NI];
    logic        err_oor_o  [NI];
    logic        err_stk_o  [NI];

    int cyc;
    int total;
    int bad;

    initial clka = 1'b0;
    always #5 clka = ~clka;

    always @(posedge clka) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        logic [31:0] mem  [131072];
        logic [31:0] pipe [L];

        bram_port_arbiter #(
            .DATA_W (32),
            .ADDR_W (32),
            .DEPTH  (DEPTH),
            .RD_LAT (L)
        ) dut (
            .clka       (clka),
            .rst        (rst),
            .w_req      (w_req),
            .w_addr     (w_addr),
            .w_data     (w_data),
            .w_gnt      (w_gnt_o[g]),
            .r_req      (r_req),
            .r_addr     (r_addr),
            .r_gnt      (r_gnt_o[g]),
            .r_data     (r_data_o[g]),
            .r_valid    (r_valid_o[g]),
            .bram_wea   (wea_o[g]),
            .bram_addra (addra_o[g]),
            .bram_dina  (dina_o[g]),
            .bram_douta (douta_i[g]),
            .err_oor    (err_oor_o[g]),
            .err_sticky (err_stk_o[g]),
            .err_clr    (err_clr)
        );

        // Behavioural single-port BRAM with L cycles of read latency.
        always @(posedge clka) begin
            if (wea_o[g]) mem[addra_o[g][16:0]] <= dina_o[g];
            pipe[0] <= mem[addra_o[g][16:0]];
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign douta_i[g] = pipe[L-1];
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 4);
    endfunction

    function automatic string tg(input string s, input int i);
        return $sformatf("%s[lat%0d]", s, lat_of(i));
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    typedef struct packed {
        logic [31:0] c;
        logic [31:0] d;
    } rd_t;

    rd_t         exp_q [NI][$];
    logic [31:0] ref_mem [int unsigned];
    bit          last_was_w;
    bit          m_sticky;
    bit          m_oor;
    bit          m_wea;
    logic [31:0] m_addra;
    logic [31:0] m_dina;

    initial begin
        bit          eg_w, eg_r, nxt_oor, ev;
        logic [31:0] ed, rd;
        rd_t         t;
        last_was_w = 1'b0;
        forever begin
            @(negedge clka);
            if (rst) begin
                for (int i = 0; i < NI; i++) begin
                    chk(tg("rst_wea", i), wea_o[i], 0);
                    chk(tg("rst_addra", i), addra_o[i], 0);
                    chk(tg("rst_dina", i), dina_o[i], 0);
                    chk(tg("rst_rvalid", i), r_valid_o[i], 0);
                    chk(tg("rst_oor", i), err_oor_o[i], 0);
                    chk(tg("rst_sticky", i), err_stk_o[i], 0);
                    exp_q[i].delete();
                end
                last_was_w = 1'b0;
                m_sticky = 0; m_oor = 0; m_wea = 0; m_addra = '0; m_dina = '0;
            end else begin
                for (int i = 0; i < NI; i++) begin
                    while (exp_q[i].size() > 0 && exp_q[i][0].c < cyc) void'(exp_q[i].pop_front());
                    ev = 0; ed = '0;
                    if (exp_q[i].size() > 0 && exp_q[i][0].c == cyc) begin
                        t = exp_q[i].pop_front();
                        ev = 1; ed = t.d;
                    end
                    chk(tg("r_valid", i), r_valid_o[i], ev);
                    if (ev) chk(tg("r_data", i), r_data_o[i], ed);
                    chk(tg("err_oor", i), err_oor_o[i], m_oor);
                    chk(tg("err_sticky", i), err_stk_o[i], m_sticky);
                    chk(tg("bram_wea", i), wea_o[i], m_wea);
                    chk(tg("bram_addra", i), addra_o[i], m_addra);
                    chk(tg("bram_dina", i), dina_o[i], m_dina);
                end
                // Tie goes to whoever was not granted most recently.
                eg_w = w_req && (!r_req || !last_was_w);
                eg_r = r_req && !eg_w;
                for (int i = 0; i < NI; i++) begin
                    chk(tg("w_gnt", i), w_gnt_o[i], eg_w);
                    chk(tg("r_gnt", i), r_gnt_o[i], eg_r);
                end
                if (eg_w) last_was_w = 1'b1;
                if (eg_r) last_was_w = 1'b0;
                nxt_oor = 0;
                m_wea = 0;
                if (eg_w) begin
                    if (w_addr < DEPTH) begin
                        ref_mem[w_addr] = w_data;
                        m_wea = 1; m_addra = w_addr; m_dina = w_data;
                    end else nxt_oor = 1;
                end
                if (eg_r) begin
                    if (r_addr < DEPTH) begin
                        m_addra = r_addr;
                        rd = ref_mem.exists(r_addr) ? ref_mem[r_addr] : 32'h0;
                        for (int i = 0; i < NI; i++) begin
                            t.c = cyc + 1 + lat_of(i);
                            t.d = rd;
                            exp_q[i].push_back(t);
                        end
                    end else nxt_oor = 1;
                end
                m_sticky = m_oor || (m_sticky && !err_clr);
                m_oor = nxt_oor;
            end
        end
    end

    // ---------------- stimulus ----------------
    logic last_wg, last_rg;

    task automatic step(input logic wq, input logic [31:0] wa, input logic [31:0] wd,
                        input logic rq, input logic [31:0] ra, input logic clr);
        w_req = wq; w_addr = wa; w_data = wd;
        r_req = rq; r_addr = ra; err_clr = clr;
        #3;
        last_wg = w_gnt_o[0];
        last_rg = r_gnt_o[0];
        @(posedge clka);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] pick_addr(input bit allow_oor);
        int r;
        r = $urandom_range(0, 15);
        if (allow_oor && r == 0) return 32'hFFFF_FFFF;
        if (allow_oor && r == 1) return 32'(DEPTH) + $urandom_range(0, 1000);
        if (r < 9) return $urandom_range(0, 255);
        return 32'(DEPTH - 256) + $urandom_range(0, 255);
    endfunction

    initial begin
        int nw, nr;
        logic [31:0] a;
        cyc = 0; total = 0; bad = 0;
        rst = 1'b1;
        w_req = 0; w_addr = 0; w_data = 0; r_req = 0; r_addr = 0; err_clr = 0;
        repeat (3) @(posedge clka);
        #1;
        rst = 1'b0;
        idle(2);

        // Fill the low and high ends of the buffer, then read it back-to-back.
        for (int k = 0; k < 512; k++) begin
            a = (k < 256) ? 32'(k) : 32'(DEPTH - 512 + k);
            step(1, a, a + 1, 0, 0, 0);
        end
        for (int k = 0; k < 512; k++) begin
            a = (k < 256) ? 32'(k) : 32'(DEPTH - 512 + k);
            step(0, 0, 0, 1, a, 0);
        end
        idle(6);

        // Both requesters held high: strict alternation.
        nw = 0; nr = 0;
        for (int k = 0; k < 10; k++) begin
            a = pick_addr(0);
            step(1, a, $urandom, 1, pick_addr(0), 0);
            nw += int'(last_wg);
            nr += int'(last_rg);
        end
        chk("contention_writes", nw, 5);
        chk("contention_reads", nr, 5);
        idle(6);

        // Read-after-write on consecutive grants.
        step(1, 7, 32'hDEAD_BEEF, 0, 0, 0);
        step(0, 0, 0, 1, 7, 0);
        idle(6);

        // Out-of-range accesses and clear/set collision.
        step(0, 0, 0, 1, DEPTH, 0);
        step(1, 32'hFFFF_FFFF, 32'h1234, 0, 0, 0);
        idle(3);
        chk("oor_sticky_set", err_stk_o[0], 1);
        step(1, DEPTH + 5, 32'h55, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("oor_clr_collision", err_stk_o[0], 1);
        step(0, 0, 0, 0, 0, 1);
        idle(1);
        chk("oor_clr_alone", err_stk_o[0], 0);
        idle(2);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 1), pick_addr(1), $urandom, $urandom_range(0, 1),
                 pick_addr(1), ($urandom_range(0, 7) == 0));
        end
        idle(6);

        // Reset with three reads in flight, then a tie right after release.
        step(0, 0, 0, 1, 3, 0);
        step(0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 1, 5, 0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        step(1, 9, 32'hCAFE, 1, 10, 0);
        chk("post_rst_first_w", last_wg, 1);
        chk("post_rst_first_r", last_rg, 0);
        step(0, 0, 0, 1, 9, 0);
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
